// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - 640x480@60 VGA timing generator with registered, pixel-aligned sync and color outputs.
// Geometry is parameterised; the defaults give the standard 800x525 raster.
module vga_sync #(
   parameter int CLK_DIV  = 4,
   parameter int SYNC_POL = 0,
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [11:0] color_in,
   output logic [9:0]  vga_column,
   output logic [8:0]  vga_row,
   output logic        hs,
   output logic        vs,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b,
   output logic        visible,
   output logic        frame_start
);

   localparam int DIV_W = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

   localparam logic SYNC_ON  = SYNC_POL[0];
   localparam logic SYNC_OFF = ~SYNC_POL[0];

   logic [DIV_W-1:0] div_cnt;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic             pix_tick;
   logic             h_vis;
   logic             v_vis;
   logic             h_in_sync;
   logic             v_in_sync;
   logic             pix_vis;

   assign pix_tick  = (div_cnt == DIV_LAST);
   assign h_vis     = (h_cnt < H_ACT_END);
   assign v_vis     = (v_cnt < V_ACT_END);
   assign h_in_sync = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
   assign v_in_sync = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
   assign pix_vis   = h_vis && v_vis;

   assign vga_column = h_vis ? h_cnt : 10'd0;
   assign vga_row    = v_vis ? v_cnt[8:0] : 9'd0;

   // Outputs latch the pixel the counters hold *before* they advance, so sync,
   // visible and color all describe the same pixel.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_cnt     <= '0;
         h_cnt       <= 10'd0;
         v_cnt       <= 10'd0;
         hs          <= SYNC_OFF;
         vs          <= SYNC_OFF;
         r           <= 4'd0;
         g           <= 4'd0;
         b           <= 4'd0;
         visible     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (pix_tick) begin
            div_cnt   <= '0;
            hs        <= h_in_sync ? SYNC_ON : SYNC_OFF;
            vs        <= v_in_sync ? SYNC_ON : SYNC_OFF;
            visible   <= pix_vis;
            {r, g, b} <= pix_vis ? color_in : 12'h000;
            if (h_cnt == H_LAST) begin
               h_cnt <= 10'd0;
               if (v_cnt == V_LAST) begin
                  v_cnt       <= 10'd0;
                  frame_start <= 1'b1;
               end else begin
                  v_cnt <= v_cnt + 10'd1;
               end
            end else begin
               h_cnt <= h_cnt + 10'd1;
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync.sv
// tb/tb_vga_sync.sv - Self-checking bench for vga_sync: full-size raster plus a shrunken raster for frame timing.
module tb_vga_sync;

   logic        clk = 1'b0;
   logic        rstn;
   logic [11:0] color_a, color_s;
   logic [9:0]  col_a, col_s;
   logic [8:0]  row_a, row_s;
   logic        hs_a, vs_a, vis_a, fs_a, hs_s, vs_s, vis_s, fs_s;
   logic [3:0]  r_a, g_a, b_a, r_s, g_s, b_s;

   always #5 clk = ~clk;

   vga_sync dut (
      .clk(clk), .rstn(rstn), .color_in(color_a), .vga_column(col_a), .vga_row(row_a),
      .hs(hs_a), .vs(vs_a), .r(r_a), .g(g_a), .b(b_a), .visible(vis_a), .frame_start(fs_a)
   );

   // 32x13 raster, 3 clk per pixel, active-high sync: one frame is 1248 clk.
   vga_sync #(
      .CLK_DIV(3), .SYNC_POL(1), .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
      .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) dut_s (
      .clk(clk), .rstn(rstn), .color_in(color_s), .vga_column(col_s), .vga_row(row_s),
      .hs(hs_s), .vs(vs_s), .r(r_s), .g(g_s), .b(b_s), .visible(vis_s), .frame_start(fs_s)
   );

   int checks = 0;
   int fails  = 0;
   int n;
   logic [34:0] exp_a_q[$];
   logic [34:0] exp_s_q[$];
   logic [9:0]  hist1, hist2;
   logic        prev_hs_a, prev_vs_s;
   int fall_a[$], rise_a[$], vs_on_s[$], vs_off_s[$], fs_at_s[$];

   // Reference: after n edges out of reset, tick k = n/cd has shown pixel k-1 of the raster.
   function automatic logic [34:0] model(int cd, int ha, int hf, int hsw, int hb,
                                         int va, int vf, int vsw, int vb, int nn,
                                         logic ramp, logic pol);
      int ht, vt, tot, ticks, idx, h, v, p, hp, vp;
      logic [9:0]  c;
      logic [8:0]  rw;
      logic        hsv, vsv, vis, fs;
      logic [11:0] rgb;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      tot = ht * vt;
      ticks = nn / cd;
      idx = ticks % tot;
      h = idx % ht;
      v = idx / ht;
      c  = (h < ha) ? 10'(h) : 10'd0;
      rw = (v < va) ? 9'(v) : 9'd0;
      hsv = ~pol; vsv = ~pol; vis = 1'b0; rgb = 12'h000; fs = 1'b0;
      if (ticks > 0) begin
         p  = (ticks - 1) % tot;
         hp = p % ht;
         vp = p / ht;
         hsv = (hp >= ha + hf && hp < ha + hf + hsw) ? pol : ~pol;
         vsv = (vp >= va + vf && vp < va + vf + vsw) ? pol : ~pol;
         vis = (hp < ha) && (vp < va);
         rgb = vis ? (ramp ? 12'(hp) : 12'hFFF) : 12'h000;
         fs  = (nn % cd == 0) && (ticks % tot == 0);
      end
      return {c, rw, hsv, vsv, rgb, vis, fs};
   endfunction

   function automatic int at(int q[$], int i);
      return (q.size() > i) ? q[i] : -1;
   endfunction

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, n);
      end
   endtask

   task automatic clear_records();
      fall_a.delete(); rise_a.delete(); vs_on_s.delete(); vs_off_s.delete(); fs_at_s.delete();
      prev_hs_a = 1'b1;
      prev_vs_s = 1'b0;
      hist1 = 10'd0;
      hist2 = 10'd0;
   endtask

   task automatic step();
      int nn;
      nn = rstn ? n + 1 : 0;
      exp_a_q.push_back(model(4, 640, 16, 96, 48, 480, 10, 2, 33, nn, 1'b1, 1'b0));
      exp_s_q.push_back(model(3, 16, 4, 8, 4, 6, 2, 2, 3, nn, 1'b0, 1'b1));
      @(posedge clk);
      #1;
      if (rstn) begin
         n++;
         if (prev_hs_a && !hs_a) fall_a.push_back(n);
         if (!prev_hs_a && hs_a) rise_a.push_back(n);
         if (!prev_vs_s && vs_s) vs_on_s.push_back(n);
         if (prev_vs_s && !vs_s) vs_off_s.push_back(n);
         if (fs_s) fs_at_s.push_back(n);
         prev_hs_a = hs_a;
         prev_vs_s = vs_s;
         hist2 = hist1;
         hist1 = col_a;
         color_a = {2'b00, hist2};
      end
      check("pixel_a", {col_a, row_a, hs_a, vs_a, r_a, g_a, b_a, vis_a, fs_a}, exp_a_q.pop_front());
      check("pixel_s", {col_s, row_s, hs_s, vs_s, r_s, g_s, b_s, vis_s, fs_s}, exp_s_q.pop_front());
   endtask

   initial begin
      int guard;
      n = 0;
      color_a = 12'hFFF;
      color_s = 12'hFFF;
      clear_records();
      rstn = 1'b1;
      #2 rstn = 1'b0;
      #1;
      check("rst_hs_a", hs_a, 1'b1);
      check("rst_vs_a", vs_a, 1'b1);
      check("rst_rgb_a", {r_a, g_a, b_a}, 12'h000);
      check("rst_vis_a", vis_a, 1'b0);
      check("rst_col_row_a", {col_a, row_a}, 19'd0);
      check("rst_sync_s", {hs_s, vs_s}, 2'b00);
      repeat (5) step();

      rstn = 1'b1;
      color_a = 12'h000;
      repeat (7000) step();
      check("hs_first_fall", at(fall_a, 0), 2628);
      check("hs_low_len", at(rise_a, 0) - at(fall_a, 0), 384);
      check("hs_period", at(fall_a, 1) - at(fall_a, 0), 3200);
      check("vs_s_first_on", at(vs_on_s, 0), 771);
      check("vs_s_active_len", at(vs_off_s, 0) - at(vs_on_s, 0), 192);
      check("fs_s_first", at(fs_at_s, 0), 1248);
      check("fs_s_period", at(fs_at_s, 1) - at(fs_at_s, 0), 1248);
      check("fs_s_count", fs_at_s.size(), 5);

      // Run the small raster to pixel (24,9): inside both sync pulses.
      guard = 0;
      while (!((n % 3 == 0) && (((n / 3) - 1) % 416 == 312)) && guard < 2000) begin
         step();
         guard++;
      end
      check("mid_reached", guard < 2000, 1'b1);
      check("mid_pre_sync_s", {hs_s, vs_s}, 2'b11);
      #2 rstn = 1'b0;
      #1;
      check("mid_async_sync_s", {hs_s, vs_s}, 2'b00);
      check("mid_async_sync_a", {hs_a, vs_a}, 2'b11);
      check("mid_async_rgb_s", {r_s, g_s, b_s, vis_s}, 13'd0);
      n = 0;
      clear_records();
      color_a = 12'h000;
      repeat (3) step();
      rstn = 1'b1;
      repeat (3000) step();
      check("restart_hs_fall", at(fall_a, 0), 2628);
      check("restart_fs_s", at(fs_at_s, 0), 1248);
      check("restart_vs_s_on", at(vs_on_s, 0), 771);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per pixel; legal range 3..16.
REQ-002 Parameter SYNC_POL, default 0: active level of hs/vs (0 = active-low).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 color_in  input  12  pixel color from the text renderer, {R[11:8],G[7:4],B[3:0]}, valid 2 clk after vga_column/vga_row change.
REQ-006 vga_column  output  10  current visible pixel column, 0..639.
REQ-007 vga_row  output  9  current visible pixel row, 0..479.
REQ-008 hs  output  1  horizontal sync, registered.
REQ-009 vs  output  1  vertical sync, registered.
REQ-010 r, g, b  output  4 each  registered pixel color to the DAC.
REQ-011 visible  output  1  high while r/g/b carry an active-area pixel.
REQ-012 frame_start  output  1  one-clk pulse at each frame wrap.

Function
REQ-013 Divider div_cnt counts 0..CLK_DIV-1 and wraps; pix_tick is high only when div_cnt == CLK_DIV-1, so it is one clk wide every CLK_DIV clk.
REQ-014 Horizontal counter h_cnt (10 bit) counts 0..799 and advances only on pix_tick; at 799 it wraps to 0 and advances v_cnt.
REQ-015 Vertical counter v_cnt (10 bit) counts 0..524; on pix_tick with h_cnt==799 and v_cnt==524, both wrap to 0.
REQ-016 Horizontal regions: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-017 Vertical regions: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-018 vga_column = h_cnt when h_cnt<640, else 0; vga_row = v_cnt[8:0] when v_cnt<480, else 0; both combinational from the counters.
REQ-019 On pix_tick, all output registers sample the position currently held by the counters (before advance): hs active iff h_cnt in 656..751; vs active iff v_cnt in 490..491; visible = (h_cnt<640 && v_cnt<480).
REQ-020 On the same pix_tick, {r,g,b} = color_in if the pixel is visible, else 12'h000, so color and sync stay aligned to the same pixel.
REQ-021 color_in is sampled CLK_DIV-1 clk after the counters last changed; CLK_DIV>=3 guarantees it has passed the renderer's 2-clk RAM+ROM latency.
REQ-022 Outputs hold their values between pix_ticks; no output changes on a non-tick clk except frame_start.
REQ-023 frame_start is high for exactly the clk after the pix_tick on which the counters wrap from (799,524) to (0,0).
REQ-024 Sync output level: active = SYNC_POL, inactive = ~SYNC_POL.
REQ-025 Derived timing at CLK_DIV=4: line = 3200 clk; hs active 384 clk; frame = 1,680,000 clk; vs active 6400 clk.

Reset
REQ-026 While rstn=0, asynchronously: div_cnt=0, h_cnt=0, v_cnt=0, r=g=b=0, visible=0, frame_start=0, hs=vs=~SYNC_POL.
REQ-027 On release of rstn, the first pix_tick occurs CLK_DIV clk later and outputs pixel (0,0).
REQ-028 Reset asserted mid-frame abandons the frame immediately; no partial sync pulse continues after rstn falls.

Verification
REQ-029 Reset: hold rstn=0, color_in=12'hFFF -> hs=vs=1, rgb=0, visible=0, vga_column=0, vga_row=0.
REQ-030 Line timing, CLK_DIV=4: hs low exactly 384 clk; falling-edge-to-falling-edge interval 3200 clk; first hs fall occurs 657 pix_ticks after reset release.
REQ-031 Frame timing: vs low exactly 6400 clk; frame_start pulses 1,680,000 clk apart, each 1 clk wide.
REQ-032 Blanking: color_in=12'hFFF constant -> rgb=0 and visible=0 for h_cnt 640..799 and for all of lines 480..524; rgb=12'hFFF elsewhere.
REQ-033 Alignment: model color_in = {2'b0,vga_column} delayed 2 clk -> after the tick for column N (N<640), {r,g,b} == N with no skew.
REQ-034 Mid-frame reset at h_cnt=700, v_cnt=491 (sync active) -> hs, vs go inactive asynchronously; after release, timing restarts from (0,0) per REQ-027.
